// File: rtl/mpsoc_uart_pkg.sv
// Shared types for the UART receive path: FSM states, FIFO entry layout, oversampling constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mpsoc_uart_pkg;

  localparam int OS_RATE = 16;  // ticks per bit
  localparam int OS_MID  = 7;   // tick index used as mid-bit for the start bit

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    PUSH
  } rx_state_t;

  // brk stands for the line-break indication (break is a reserved word)
  typedef struct packed {
    logic       brk;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  // Index of the last data bit for a given character-length code (0:5b .. 3:8b)
  function automatic logic [2:0] last_bit_idx(input logic [1:0] bits_code);
    return 3'({1'b0, bits_code}) + 3'd4;
  endfunction

endpackage

// File: rtl/mpsoc_uart_rx_fifo.sv
// First-word-fall-through FIFO of received characters with flush, occupancy and drop indication.
// Latency: head valid the cycle after a push into an empty FIFO.
// Backpressure: push into a full FIFO is dropped (overflow pulse) unless a pop happens the same cycle.
module mpsoc_uart_rx_fifo
  import mpsoc_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     clear,
  input  logic                     push_vld,
  input  rx_entry_t                push_dat,
  input  logic                     pop_rdy,
  output rx_entry_t                head_dat,
  output logic                     head_vld,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_rdy && !empty && !clear;
  assign push_ok = push_vld && (!full || pop_ok) && !clear;

  // Storage array; contents are only observed through the valid-masked head
  always_ff @(posedge HCLK) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_dat;
    end
  end

  // Pointers, occupancy and the drop pulse; flush wins over any push or pop
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_vld && full && !pop_ok;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head_vld = !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr_q];
  assign overflow = overflow_q;
  assign level    = count_q;

endmodule

// File: rtl/mpsoc_uart_rx_deframer.sv
// UART receiver: synchronises rx, recovers 5-8 bit frames with parity/stop checks at 16x oversampling.
// Latency: entry visible SYNC_DEPTH + ~9.5 bit times + 2 cycles after the start edge.
// Backpressure: valid/ready on the FIFO head; frames arriving while the FIFO is full are dropped.
module mpsoc_uart_rx_deframer
  import mpsoc_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_DEPTH = 3,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          clear_i,
  input  logic [DIV_WIDTH-1:0]          cfg_div_i,
  input  logic [1:0]                    cfg_bits_i,
  input  logic                          cfg_parity_en_i,
  input  logic                          cfg_parity_odd_i,
  input  logic                          cfg_stop2_i,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_perr_o,
  output logic                          rx_ferr_o,
  output logic                          rx_break_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  rx_s;
  logic                  rx_prev_q;

  logic [DIV_WIDTH-1:0]  div_cnt_q;
  logic [DIV_WIDTH-1:0]  div_lim;
  logic                  tick;

  rx_state_t             state_q;
  logic                  armed_q;
  logic [3:0]            os_cnt_q;
  logic [2:0]            bit_cnt_q;
  logic                  stop_cnt_q;
  logic [7:0]            data_q;
  logic                  par_bit_q;
  logic                  perr_q;
  logic                  ferr_q;

  logic [DIV_WIDTH-1:0]  div_sh_q;
  logic [1:0]            bits_sh_q;
  logic                  par_en_sh_q;
  logic                  par_odd_sh_q;
  logic                  stop2_sh_q;

  logic                  start_det;
  logic                  bit_end;
  logic                  push_vld;
  rx_entry_t             push_dat;
  rx_entry_t             head_dat;

  assign rx_s = sync_q[SYNC_DEPTH-1];

  // Metastability chain on the raw line plus one delayed copy for falling-edge detection
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_DEPTH-2:0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  // Live divisor while idle so the tick tracks configuration; frozen copy once a frame starts
  assign div_lim   = (state_q == IDLE) ? cfg_div_i : div_sh_q;
  assign tick      = (div_cnt_q >= div_lim);
  assign start_det = (state_q == IDLE) && armed_q && rx_prev_q && !rx_s;
  assign bit_end   = tick && (os_cnt_q == 4'(OS_RATE - 1));

  // Oversample tick generator; realigned to the start edge so samples land mid-bit
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      div_cnt_q <= '0;
    end else if (start_det || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Frame recovery state machine; advances on ticks apart from edge detect and the push cycle
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      armed_q      <= 1'b1;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      data_q       <= '0;
      par_bit_q    <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      div_sh_q     <= '0;
      bits_sh_q    <= '0;
      par_en_sh_q  <= 1'b0;
      par_odd_sh_q <= 1'b0;
      stop2_sh_q   <= 1'b0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      armed_q  <= 1'b1;
      os_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // After a framing error the line must return high before a new start is accepted
          if (!armed_q && rx_s) begin
            armed_q <= 1'b1;
          end
          if (start_det) begin
            state_q      <= START;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            data_q       <= '0;
            par_bit_q    <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            div_sh_q     <= cfg_div_i;
            bits_sh_q    <= cfg_bits_i;
            par_en_sh_q  <= cfg_parity_en_i;
            par_odd_sh_q <= cfg_parity_odd_i;
            stop2_sh_q   <= cfg_stop2_i;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt_q == 4'(OS_MID)) begin
              os_cnt_q <= '0;
              // A start bit that is high again at mid-bit was a glitch
              state_q  <= rx_s ? IDLE : DATA;
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_end) begin
              os_cnt_q          <= '0;
              data_q[bit_cnt_q] <= rx_s;
              if (bit_cnt_q == last_bit_idx(bits_sh_q)) begin
                bit_cnt_q <= '0;
                state_q   <= par_en_sh_q ? PARITY : STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (bit_end) begin
              os_cnt_q  <= '0;
              par_bit_q <= rx_s;
              perr_q    <= ((^data_q) ^ rx_s) != par_odd_sh_q;
              state_q   <= STOP;
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_end) begin
              os_cnt_q <= '0;
              if (!rx_s) begin
                ferr_q <= 1'b1;
              end
              if (stop2_sh_q && !stop_cnt_q) begin
                stop_cnt_q <= 1'b1;
              end else begin
                state_q <= PUSH;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        PUSH: begin
          state_q <= IDLE;
          if (ferr_q) begin
            armed_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Entry assembly: a break is an all-zero character with zero parity and a failed stop
  always_comb begin
    push_dat      = '0;
    push_dat.brk  = (data_q == '0) && ferr_q && !(par_en_sh_q && par_bit_q);
    push_dat.ferr = ferr_q;
    push_dat.perr = perr_q;
    push_dat.data = data_q;
  end

  assign push_vld = (state_q == PUSH);

  mpsoc_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .clear    (clear_i),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (rx_ready_i),
    .head_dat (head_dat),
    .head_vld (rx_valid_o),
    .overflow (overflow_o),
    .level    (level_o)
  );

  assign rx_data_o  = head_dat.data;
  assign rx_perr_o  = head_dat.perr;
  assign rx_ferr_o  = head_dat.ferr;
  assign rx_break_o = head_dat.brk;

endmodule
